// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: next-PC select encodings, bubble instruction,
// fetch FSM states and the IF/ID register layout.
package fetch_stage_pkg;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_JALR = 2'b01;
  localparam logic [1:0] NPC_JBR  = 2'b10;

  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_KILL = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcadd4;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  function automatic if_id_t make_bubble(input logic [31:0] nop);
    if_id_t b;
    b.pc     = '0;
    b.pcadd4 = '0;
    b.inst   = nop;
    b.valid  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_seg_reg.sv
// Generic pipeline segment register: flush beats stall, stall beats load,
// and an unloaded cycle falls back to the flush value (a bubble).
module seg_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic [W-1:0] flush_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RST_VAL;
    else if (flush)
      q <= flush_val;
    else if (!stall)
      q <= load ? d : flush_val;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a req/ack imem port, discards responses
// made stale by a redirect and buffers a response that arrives while decode is stalled.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        stall_if2id,
  input  logic        flush_if2id,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] pc_jalr,
  input  logic [31:0] pc_jbr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] pc_id,
  output logic [31:0] pcadd4_id,
  output logic [31:0] inst_id,
  output logic        valid_id
);

  localparam if_id_t BUBBLE = make_bubble(NOP_INST);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  redirect_pc_reg, redirect_pc_next;
  logic [31:0]  inst_buf_reg, inst_buf_next;
  logic         deliver;
  logic [31:0]  deliver_inst;
  logic         redir;
  logic [31:0]  tgt;
  logic [31:0]  pc_plus4;
  if_id_t       if_id_d, if_id_q;

  assign redir    = ~stall_pc & ((npc_sel == NPC_JALR) | (npc_sel == NPC_JBR));
  assign tgt      = (npc_sel == NPC_JALR) ? (pc_jalr & 32'hFFFF_FFFE) : pc_jbr;
  assign pc_plus4 = pc_reg + 32'd4;

  // The PC is frozen while a killed request is outstanding, so it doubles as
  // the latched stale address and keeps imem_addr stable until the ack.
  assign imem_req  = (state_reg != ST_HOLD);
  assign imem_addr = pc_reg;
  assign pc_if     = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_REQ;
      pc_reg          <= RESET_PC;
      redirect_pc_reg <= '0;
      inst_buf_reg    <= NOP_INST;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      redirect_pc_reg <= redirect_pc_next;
      inst_buf_reg    <= inst_buf_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    redirect_pc_next = redirect_pc_reg;
    inst_buf_next    = inst_buf_reg;
    deliver          = 1'b0;
    deliver_inst     = imem_rdata;
    case (state_reg)
      ST_REQ: begin
        if (redir) begin
          if (imem_ack) begin
            pc_next = tgt;
          end else begin
            redirect_pc_next = tgt;
            state_next       = ST_KILL;
          end
        end else if (imem_ack) begin
          if (stall_if2id) begin
            inst_buf_next = imem_rdata;
            state_next    = ST_HOLD;
          end else begin
            deliver = 1'b1;
            if (!stall_pc)
              pc_next = pc_plus4;
          end
        end
      end
      ST_KILL: begin
        // A redirect arriving with the ack is the newest target.
        if (imem_ack) begin
          pc_next    = redir ? tgt : redirect_pc_reg;
          state_next = ST_REQ;
        end else if (redir) begin
          redirect_pc_next = tgt;
        end
      end
      ST_HOLD: begin
        if (redir) begin
          pc_next    = tgt;
          state_next = ST_REQ;
        end else if (!stall_if2id) begin
          deliver      = 1'b1;
          deliver_inst = inst_buf_reg;
          pc_next      = pc_plus4;
          state_next   = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  assign if_id_d = '{pc: pc_reg, pcadd4: pc_plus4, inst: deliver_inst, valid: 1'b1};

  seg_reg #(
    .W       ($bits(if_id_t)),
    .RST_VAL (BUBBLE)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall_if2id),
    .flush     (flush_if2id),
    .load      (deliver),
    .d         (if_id_d),
    .flush_val (BUBBLE),
    .q         (if_id_q)
  );

  assign pc_id     = if_id_q.pc;
  assign pcadd4_id = if_id_q.pcadd4;
  assign inst_id   = if_id_q.inst;
  assign valid_id  = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait and hand-driven imem, stalls,
// redirects, stale-response kill, asynchronous reset and PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pc, stall_if2id, flush_if2id;
  logic [1:0]  npc_sel;
  logic [31:0] pc_jalr, pc_jbr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_if, pc_id, pcadd4_id, inst_id;
  logic        valid_id;

  logic        auto_ack;
  logic        man_ack;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Memory model: zero-wait (ack follows req) or hand-driven ack.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = (imem_addr == 32'h0040_0008) ? 32'h00A0_0093 : {imem_addr[31:2], 2'b11};

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_pc    (stall_pc),
    .stall_if2id (stall_if2id),
    .flush_if2id (flush_if2id),
    .npc_sel     (npc_sel),
    .pc_jalr     (pc_jalr),
    .pc_jbr      (pc_jbr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_if       (pc_if),
    .pc_id       (pc_id),
    .pcadd4_id   (pcadd4_id),
    .inst_id     (inst_id),
    .valid_id    (valid_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_pc = 1'b0; stall_if2id = 1'b0; flush_if2id = 1'b0;
    npc_sel = 2'b00; pc_jalr = '0; pc_jbr = '0; auto_ack = 1'b1; man_ack = 1'b0;
    step(); step();
    check("rst_pc_if",     pc_if,     32'h0040_0000);
    check("rst_pc_id",     pc_id,     32'h0);
    check("rst_pcadd4_id", pcadd4_id, 32'h0);
    check("rst_inst_id",   inst_id,   32'h0000_0013);
    check("rst_valid_id",  {31'b0, valid_id}, 32'h1 - 32'h1);
    check("rst_req",       {31'b0, imem_req}, 32'h1);
    rst = 1'b0;

    // 1. zero-wait sequential fetch
    step();
    check("t1_valid0",  {31'b0, valid_id}, 32'h1);
    check("t1_pc_id0",  pc_id,     32'h0040_0000);
    check("t1_pcadd4",  pcadd4_id, 32'h0040_0004);
    check("t1_inst0",   inst_id,   32'h0040_0003);
    check("t1_pc_if1",  pc_if,     32'h0040_0004);
    npc_sel = 2'b11;  // reserved encoding behaves as sequential
    step();
    check("t1_pc_id1",  pc_id,     32'h0040_0004);
    check("t1_pc_if2",  pc_if,     32'h0040_0008);
    npc_sel = 2'b00;

    // 2. decode and PC stalled while the response at 0x00400008 arrives
    stall_pc = 1'b1; stall_if2id = 1'b1;
    step();
    check("t2_hold_pc_id", pc_id, 32'h0040_0004);
    check("t2_hold_req",   {31'b0, imem_req}, 32'h0);
    step();
    check("t2_hold_pc_id2", pc_id, 32'h0040_0004);
    check("t2_hold_pc_if",  pc_if, 32'h0040_0008);
    stall_pc = 1'b0; stall_if2id = 1'b0;
    step();
    check("t2_inst",  inst_id, 32'h00A0_0093);
    check("t2_pc_id", pc_id,   32'h0040_0008);
    check("t2_pc_if", pc_if,   32'h0040_000C);
    check("t2_valid", {31'b0, valid_id}, 32'h1);

    // 3. branch redirect with flush, zero-wait
    npc_sel = 2'b10; pc_jbr = 32'h0040_0100; flush_if2id = 1'b1;
    step();
    check("t3_valid_bubble", {31'b0, valid_id}, 32'h0);
    check("t3_inst_nop",     inst_id, 32'h0000_0013);
    check("t3_pc_if",        pc_if,   32'h0040_0100);
    npc_sel = 2'b00; flush_if2id = 1'b0;
    step();
    check("t3_pc_id", pc_id, 32'h0040_0100);
    check("t3_valid", {31'b0, valid_id}, 32'h1);
    check("t3_pc_if_next", pc_if, 32'h0040_0104);

    // 4. slow imem, jalr redirect during the first wait cycle
    auto_ack = 1'b0; man_ack = 1'b0;
    npc_sel = 2'b01; pc_jalr = 32'h0040_0201;
    step();
    check("t4_kill_addr",  imem_addr, 32'h0040_0104);
    check("t4_kill_req",   {31'b0, imem_req}, 32'h1);
    check("t4_kill_valid", {31'b0, valid_id}, 32'h0);
    npc_sel = 2'b00;
    step();
    check("t4_kill_addr2", imem_addr, 32'h0040_0104);
    man_ack = 1'b1;
    step();
    check("t4_stale_inst",  inst_id,   32'h0000_0013);
    check("t4_stale_valid", {31'b0, valid_id}, 32'h0);
    check("t4_new_addr",    imem_addr, 32'h0040_0200);
    man_ack = 1'b0;
    step();
    check("t4_wait_addr", imem_addr, 32'h0040_0200);
    man_ack = 1'b1;
    step();
    check("t4_pc_id", pc_id,   32'h0040_0200);
    check("t4_inst",  inst_id, 32'h0040_0203);
    check("t4_pc_if", pc_if,   32'h0040_0204);
    man_ack = 1'b0; auto_ack = 1'b1;

    // 5. stall_pc beats a simultaneous redirect
    stall_pc = 1'b1; npc_sel = 2'b10; pc_jbr = 32'h0040_0300;
    step();
    check("t5_pc_held", pc_if, 32'h0040_0204);
    check("t5_pc_id",   pc_id, 32'h0040_0204);
    stall_pc = 1'b0;
    step();
    check("t5_redirect", pc_if, 32'h0040_0300);
    check("t5_bubble",   {31'b0, valid_id}, 32'h0);
    npc_sel = 2'b00;

    // 6. asynchronous reset in KILL with a real instruction held in IF/ID
    step();
    check("t6_pre_pc_id", pc_id, 32'h0040_0300);
    auto_ack = 1'b0; man_ack = 1'b0; stall_if2id = 1'b1;
    npc_sel = 2'b10; pc_jbr = 32'h0040_0400;
    step();
    check("t6_kill_addr", imem_addr, 32'h0040_0304);
    check("t6_kept_valid", {31'b0, valid_id}, 32'h1);
    npc_sel = 2'b00; stall_if2id = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_pc_if",  pc_if, 32'h0040_0000);
    check("t6_rst_pc_id",  pc_id, 32'h0);
    check("t6_rst_valid",  {31'b0, valid_id}, 32'h0);
    check("t6_rst_inst",   inst_id, 32'h0000_0013);
    check("t6_rst_addr",   imem_addr, 32'h0040_0000);
    #1 rst = 1'b0; auto_ack = 1'b1;
    step();
    check("t6_req_after", {31'b0, imem_req}, 32'h1);
    check("t6_pc_id",     pc_id, 32'h0040_0000);
    check("t6_pc_if",     pc_if, 32'h0040_0004);

    // PC wraps modulo 2^32
    npc_sel = 2'b10; pc_jbr = 32'hFFFF_FFFC;
    step();
    check("wrap_pc_if", pc_if, 32'hFFFF_FFFC);
    npc_sel = 2'b00;
    step();
    check("wrap_pc_id",  pc_id,     32'hFFFF_FFFC);
    check("wrap_pcadd4", pcadd4_id, 32'h0);
    check("wrap_pc_if0", pc_if,     32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
